// File: rtl/code_storage_loader.sv
`default_nettype none
// ============================================================================
// code_storage_loader : assembles 12-bit words from a host byte stream and
// writes them to consecutive code storage lines, then enables the storage.
// Revision: 1.0
// ============================================================================
module code_storage_loader #(
  parameter int MAX_LINES  = 4096,
  parameter int LINE_WIDTH = 32
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [11:0]           write_data,
  output logic                  is_write,
  output logic [LINE_WIDTH-1:0] write_line,
  output logic                  storage_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int IDX_W = $clog2(MAX_LINES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    W_HI   = 3'd3,
    W_LO   = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [7:0]         count_hi;
  logic [15:0]        count;
  logic [3:0]         nibble;
  logic [IDX_W-1:0]   index;

  logic               accept;
  logic [15:0]        header;
  logic               last_word;

  assign accept    = in_valid && in_ready;
  assign header    = {count_hi, in_data};
  // index never exceeds MAX_LINES, so the widened compare cannot alias
  assign last_word = ((32'(index) + 32'd1) == 32'(count));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE, ERROR: begin
        if (start) state_nx = HDR_HI;
      end
      HDR_HI: begin
        if (accept) state_nx = HDR_LO;
      end
      HDR_LO: begin
        if (accept) begin
          if (header == 16'd0)
            state_nx = DONE;
          else if (32'(header) > 32'(MAX_LINES))
            state_nx = ERROR;
          else
            state_nx = W_HI;
        end
      end
      W_HI: begin
        if (accept) state_nx = (in_data[7:4] != 4'd0) ? ERROR : W_LO;
      end
      W_LO: begin
        if (accept) state_nx = WRITE;
      end
      WRITE: begin
        state_nx = last_word ? DONE : W_HI;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state          <= IDLE;
      count_hi       <= 8'd0;
      count          <= 16'd0;
      nibble         <= 4'd0;
      index          <= '0;
      in_ready       <= 1'b0;
      is_write       <= 1'b0;
      write_data     <= 12'd0;
      write_line     <= '0;
      storage_enable <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_nx;
      in_ready       <= (state_nx inside {HDR_HI, HDR_LO, W_HI, W_LO});
      busy           <= (state_nx inside {HDR_HI, HDR_LO, W_HI, W_LO, WRITE});
      is_write       <= (state_nx == WRITE);
      done           <= (state_nx == DONE);
      storage_enable <= (state_nx == DONE);
      error          <= (state_nx == ERROR);

      if (accept && (state == HDR_HI)) begin
        count_hi <= in_data;
      end
      if (accept && (state == HDR_LO)) begin
        count <= header;
        index <= '0;
      end
      if (accept && (state == W_HI)) begin
        nibble <= in_data[3:0];
      end
      if (accept && (state == W_LO)) begin
        write_data <= {nibble, in_data};
        write_line <= LINE_WIDTH'(index);
      end
      if (state == WRITE) begin
        index <= index + IDX_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_code_storage_loader.sv
`default_nettype none
// Testbench for code_storage_loader: randomized byte streams, reference stream
// parser, and a write scoreboard fed at stimulus time and drained by a monitor.
module tb_code_storage_loader;

  localparam int MAXL = 4096;
  localparam int LW   = 32;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [11:0]   write_data;
  logic          is_write;
  logic [LW-1:0] write_line;
  logic          storage_enable;
  logic          busy;
  logic          done;
  logic          error;

  code_storage_loader #(.MAX_LINES(MAXL), .LINE_WIDTH(LW)) dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .start          (start),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .write_data     (write_data),
    .is_write       (is_write),
    .write_line     (write_line),
    .storage_enable (storage_enable),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    int line;
    int data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks   = 0;
  int  failures = 0;
  int  accepts  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts accepted bytes and checks each write strobe against the scoreboard.
  always @(negedge clk_clk) begin
    if (in_valid && in_ready) accepts++;
    if (is_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write line=%0d data=0x%0h expected=none", write_line, write_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_line", write_line, mon_e.line);
        chk("write_data", 32'(write_data), mon_e.data);
      end
    end
  end

  // Reference parser: walks the stream by the format rules and queues the writes it implies.
  task automatic model(input logic [7:0] s[$], output int consumed, output bit is_err, output int n);
    wr_t w;
    n = {s[0], s[1]};
    is_err = 1'b0;
    consumed = 2;
    if (n > MAXL) begin
      is_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (s[2 + 2*i][7:4] != 4'd0) begin
        is_err = 1'b1;
        consumed = 3 + 2*i;
        return;
      end
      w.line = i;
      w.data = s[2 + 2*i][3:0] * 256 + s[3 + 2*i];
      exp_q.push_back(w);
      consumed = 4 + 2*i;
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit rdy;
    bit ok;
    ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout byte=0x%0h accepted=0 expected=1", b);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_is_write"}, 32'(is_write), 0);
    chk({tag, "_write_data"}, 32'(write_data), 0);
    chk({tag, "_write_line"}, write_line, 0);
    chk({tag, "_storage_enable"}, 32'(storage_enable), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  task automatic run_session(input logic [7:0] s[$], input int mingap, input int maxgap,
                             input bit poke_start);
    int consumed;
    bit is_err;
    int n;
    int a0;
    model(s, consumed, is_err, n);
    pulse_start();
    chk("start_busy", 32'(busy), 1);
    chk("start_in_ready", 32'(in_ready), 1);
    chk("start_clears_error", 32'(error), 0);
    chk("start_clears_enable", 32'(storage_enable), 0);
    a0 = accepts;
    for (int i = 0; i < consumed; i++) begin
      send_byte(s[i]);
      if (i < consumed - 1) begin
        if (poke_start && i == 2) begin
          start = 1'b1;
          tick();
          start = 1'b0;
        end
        repeat ($urandom_range(maxgap, mingap)) tick();
      end
    end
    if (!is_err && n > 0) begin
      chk("busy_during_last_write", 32'(busy), 1);
      chk("done_not_early", 32'(done), 0);
      tick();
    end
    chk("end_done", 32'(done), is_err ? 0 : 1);
    chk("end_error", 32'(error), is_err ? 1 : 0);
    chk("end_storage_enable", 32'(storage_enable), is_err ? 0 : 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_in_ready", 32'(in_ready), 0);
    in_data  = 8'h5A;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("accept_count", 32'(accepts - a0), 32'(consumed));
    chk("pending_writes", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout reached=1 expected=0");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] basic[$];
    logic [7:0] s[$];
    int n;
    int w;
    int bad;

    basic = '{8'h00, 8'h03, 8'h01, 8'h23, 8'h00, 8'hAB, 8'h0F, 8'hFF};

    repeat (3) @(posedge clk_clk);
    #1;
    chk_all_zero("reset");
    reset_reset_n = 1'b1;
    tick();
    chk_all_zero("idle");

    run_session(basic, 0, 0, 1'b0);
    run_session(basic, 1, 3, 1'b1);
    s = '{8'h00, 8'h00};
    run_session(s, 0, 0, 1'b0);
    s = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h1F, 8'h00};
    run_session(s, 0, 1, 1'b0);
    s = '{8'h10, 8'h01};
    run_session(s, 0, 0, 1'b0);

    // N exactly MAX_LINES is accepted as a header.
    pulse_start();
    send_byte(8'h10);
    send_byte(8'h00);
    chk("max_hdr_error", 32'(error), 0);
    chk("max_hdr_busy", 32'(busy), 1);
    chk("max_hdr_in_ready", 32'(in_ready), 1);
    reset_reset_n = 1'b0;
    tick();
    reset_reset_n = 1'b1;
    chk_all_zero("max_hdr_reset");

    // Reset right after the first word of the basic program is written.
    mon_e.line = 0;
    mon_e.data = 12'h123;
    exp_q.push_back(mon_e);
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(basic[i]);
    tick();
    tick();
    chk("midload_first_write_seen", 32'(exp_q.size()), 0);
    reset_reset_n = 1'b0;
    tick();
    reset_reset_n = 1'b1;
    chk_all_zero("midload_reset");
    run_session(basic, 0, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      n = $urandom_range(6, 1);
      bad = ($urandom_range(4, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
      s = '{};
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
        w = $urandom_range(4095, 0);
        if (i == bad) s.push_back(8'({$urandom_range(15, 1), 4'(w >> 8)}));
        else          s.push_back(8'(w >> 8));
        s.push_back(8'(w));
      end
      run_session(s, 0, 2, k[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
